// File: rtl/ss_arith_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ss_arith_pkg : shared helpers and constants for stochastic arithmetic |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ss_arith_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int N_DEF = 6;
  localparam int CNT_W = clog2(N_DEF + 1);

  // Largest magnitude held by a symmetric two's-complement accumulator.
  function automatic int acc_limit(input int acc_w);
    return (1 << (acc_w - 1)) - 1;
  endfunction

  localparam logic SGN_POS = 1'b0;
  localparam logic SGN_NEG = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ss_popcount.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ss_popcount : combinational population count of an N-bit vector      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ss_popcount
  import ss_arith_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = clog2(N + 1)
) (
  input  logic [N-1:0]     bits,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + CNT_W'(bits[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ss_addsub_accum_n.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ss_addsub_accum_n : signed N-input stochastic adder/subtractor with   |
// | exact saturating residue accumulator. SS_ADDSUB_SATCNT_EN adds SAT_CNT|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ss_addsub_accum_n
  import ss_arith_pkg::*;
#(
  parameter int N          = 6,
  parameter int ACC_W      = 8,
  parameter int SCALE_LOG2 = 0
) (
  input  logic             CLK,
  input  logic             INIT,
  input  logic             EN,
  input  logic [N-1:0]     IN,
  input  logic [N-1:0]     SIGN,
  output logic             OUT,
  output logic             SIGN_out,
  output logic             SAT,
`ifdef SS_ADDSUB_SATCNT_EN
  output logic [15:0]      SAT_CNT,
`endif
  output logic [ACC_W-1:0] ACC
);

  localparam int c_CNT_W = clog2(N + 1);
  localparam int c_SW    = ACC_W + 1;
  localparam logic signed [c_SW-1:0] c_T = c_SW'(1 << SCALE_LOG2);
  localparam logic signed [c_SW-1:0] c_L = c_SW'(acc_limit(ACC_W));

  logic [N-1:0]              w_pos_bits, w_neg_bits;
  logic [c_CNT_W-1:0]        w_p, w_m;
  logic signed [c_SW-1:0]    w_d, w_sum, w_r;
  logic signed [ACC_W-1:0]   w_next;
  logic                      w_emit, w_neg, w_sat;

  logic                      r_out, r_sign, r_sat;
  logic signed [ACC_W-1:0]   r_acc;

  assign w_pos_bits = IN & ~SIGN;
  assign w_neg_bits = IN & SIGN;

  ss_popcount #(.N(N), .CNT_W(c_CNT_W)) u_pop_p (.bits(w_pos_bits), .count(w_p));
  ss_popcount #(.N(N), .CNT_W(c_CNT_W)) u_pop_m (.bits(w_neg_bits), .count(w_m));

  // One extra bit of headroom so ACC + D never wraps before the clamp.
  assign w_d   = $signed(c_SW'(w_p)) - $signed(c_SW'(w_m));
  assign w_sum = $signed({r_acc[ACC_W-1], r_acc}) + w_d;

  always_comb begin
    w_emit = 1'b0;
    w_neg  = 1'b0;
    w_r    = w_sum;
    if (w_sum >= c_T) begin
      w_emit = 1'b1;
      w_r    = w_sum - c_T;
    end else if (w_sum <= -c_T) begin
      w_emit = 1'b1;
      w_neg  = 1'b1;
      w_r    = w_sum + c_T;
    end
  end

  always_comb begin
    w_sat  = 1'b0;
    w_next = ACC_W'(w_r);
    if (w_r > c_L) begin
      w_sat  = 1'b1;
      w_next = ACC_W'(c_L);
    end else if (w_r < -c_L) begin
      w_sat  = 1'b1;
      w_next = ACC_W'(-c_L);
    end
  end

  always_ff @(posedge CLK) begin
    if (INIT) begin
      r_out  <= 1'b0;
      r_sign <= SGN_POS;
      r_sat  <= 1'b0;
      r_acc  <= '0;
    end else if (EN) begin
      r_out <= w_emit;
      if (w_emit) r_sign <= w_neg ? SGN_NEG : SGN_POS;
      r_sat <= w_sat;
      r_acc <= w_next;
    end else begin
      r_out <= 1'b0;
    end
  end

`ifdef SS_ADDSUB_SATCNT_EN
  logic [15:0] r_sat_cnt;

  always_ff @(posedge CLK) begin
    if (INIT) begin
      r_sat_cnt <= '0;
    end else if (EN && w_sat && (r_sat_cnt != 16'hFFFF)) begin
      r_sat_cnt <= r_sat_cnt + 16'd1;
    end
  end

  assign SAT_CNT = r_sat_cnt;
`endif

  assign OUT      = r_out;
  assign SIGN_out = r_sign;
  assign SAT      = r_sat;
  assign ACC      = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_ss_addsub_accum_n.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ss_addsub_accum_n : scoreboard bench over three configurations     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_ss_addsub_accum_n;

  typedef struct {
    int   sel;
    logic out;
    logic sgn;
    logic sat;
    int   acc;
    int   satcnt;
  } exp_t;

  logic       CLK = 1'b0;
  logic [2:0] r_init = '0;
  logic [2:0] r_en   = '0;
  logic [5:0] r_in   = '0;
  logic [5:0] r_sign = '0;

  logic [2:0] w_out, w_sgn, w_sat;
  logic [7:0] w_acc0, w_acc2;
  logic [3:0] w_acc1;
`ifdef SS_ADDSUB_SATCNT_EN
  logic [15:0] w_sc0, w_sc1, w_sc2;
`endif

  exp_t r_q[$];
  int   r_checks = 0;
  int   r_errors = 0;
  int   r_step   = 0;

  always #5 CLK = ~CLK;

  ss_addsub_accum_n #(.N(6), .ACC_W(8), .SCALE_LOG2(0)) u_dut0 (
    .CLK(CLK), .INIT(r_init[0]), .EN(r_en[0]), .IN(r_in), .SIGN(r_sign),
    .OUT(w_out[0]), .SIGN_out(w_sgn[0]), .SAT(w_sat[0]),
`ifdef SS_ADDSUB_SATCNT_EN
    .SAT_CNT(w_sc0),
`endif
    .ACC(w_acc0));

  ss_addsub_accum_n #(.N(6), .ACC_W(4), .SCALE_LOG2(0)) u_dut1 (
    .CLK(CLK), .INIT(r_init[1]), .EN(r_en[1]), .IN(r_in), .SIGN(r_sign),
    .OUT(w_out[1]), .SIGN_out(w_sgn[1]), .SAT(w_sat[1]),
`ifdef SS_ADDSUB_SATCNT_EN
    .SAT_CNT(w_sc1),
`endif
    .ACC(w_acc1));

  ss_addsub_accum_n #(.N(6), .ACC_W(8), .SCALE_LOG2(2)) u_dut2 (
    .CLK(CLK), .INIT(r_init[2]), .EN(r_en[2]), .IN(r_in), .SIGN(r_sign),
    .OUT(w_out[2]), .SIGN_out(w_sgn[2]), .SAT(w_sat[2]),
`ifdef SS_ADDSUB_SATCNT_EN
    .SAT_CNT(w_sc2),
`endif
    .ACC(w_acc2));

  task automatic drive(input int sel, input logic init, input logic en,
                       input logic [5:0] in, input logic [5:0] sgn,
                       input logic e_out, input logic e_sgn, input logic e_sat,
                       input int e_acc, input int e_sc);
    exp_t e;
    @(negedge CLK);
    r_init      = '0;
    r_en        = '0;
    r_init[sel] = init;
    r_en[sel]   = en;
    r_in        = in;
    r_sign      = sgn;
    e.sel = sel; e.out = e_out; e.sgn = e_sgn; e.sat = e_sat;
    e.acc = e_acc; e.satcnt = e_sc;
    r_q.push_back(e);
  endtask

  // Monitor: every stimulus cycle yields one registered response one edge later.
  initial begin
    exp_t e;
    int   a_acc;
    int   a_sc;
    logic a_out, a_sgn, a_sat;
    logic ok;
    forever begin
      @(posedge CLK);
      #1;
      while (r_q.size() > 0) begin
        e     = r_q.pop_front();
        a_out = w_out[e.sel];
        a_sgn = w_sgn[e.sel];
        a_sat = w_sat[e.sel];
        a_sc  = -1;
        case (e.sel)
          0:       a_acc = int'($signed(w_acc0));
          1:       a_acc = int'($signed(w_acc1));
          default: a_acc = int'($signed(w_acc2));
        endcase
`ifdef SS_ADDSUB_SATCNT_EN
        case (e.sel)
          0:       a_sc = int'(w_sc0);
          1:       a_sc = int'(w_sc1);
          default: a_sc = int'(w_sc2);
        endcase
`endif
        ok = (a_out === e.out) && (a_sgn === e.sgn) && (a_sat === e.sat) &&
             (a_acc == e.acc);
`ifdef SS_ADDSUB_SATCNT_EN
        if (e.satcnt >= 0 && a_sc != e.satcnt) ok = 1'b0;
`endif
        r_checks++;
        r_step++;
        if (!ok) begin
          r_errors++;
          $display("FAIL dut%0d step%0d: got out=%0b sgn=%0b sat=%0b acc=%0d sc=%0d, want out=%0b sgn=%0b sat=%0b acc=%0d sc=%0d",
                   e.sel, r_step, a_out, a_sgn, a_sat, a_acc, a_sc,
                   e.out, e.sgn, e.sat, e.acc, e.satcnt);
        end
      end
    end
  end

  initial begin
    // Positive accumulation and drain, T=1
    drive(0, 1, 1, 6'b000000, 6'b000000, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) drive(0, 0, 1, 6'b000111, 6'b000000, 1, 0, 0, 2 * i, -1);
    for (int i = 1; i <= 8; i++) drive(0, 0, 1, 6'b000000, 6'b000000, 1, 0, 0, 8 - i, -1);
    drive(0, 0, 1, 6'b000000, 6'b000000, 0, 0, 0, 0, -1);

    // Sign crossing from +2 with D=-5, negative drain, then cancellation
    drive(0, 0, 1, 6'b000111, 6'b000000, 1, 0, 0,  2, -1);
    drive(0, 0, 1, 6'b011111, 6'b011111, 1, 1, 0, -2, -1);
    drive(0, 0, 1, 6'b000000, 6'b000000, 1, 1, 0, -1, -1);
    drive(0, 0, 1, 6'b000000, 6'b000000, 1, 1, 0,  0, -1);
    drive(0, 0, 1, 6'b000011, 6'b000010, 0, 1, 0,  0, -1);

    // Enable hold, then INIT mid-run with EN high
    drive(0, 0, 1, 6'b111111, 6'b000000, 1, 0, 0, 5, -1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 6'b111111, 6'b000000, 0, 0, 0, 5, -1);
    drive(0, 1, 1, 6'b111111, 6'b000000, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 6'b000001, 6'b000000, 1, 0, 0, 0, -1);

    // Saturation with ACC_W=4 (L=7) and drain of exactly 7 bits
    drive(1, 1, 1, 6'b000000, 6'b000000, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 6'b111111, 6'b000000, 1, 0, 0, 5, 0);
    drive(1, 0, 1, 6'b111111, 6'b000000, 1, 0, 1, 7, 1);
    drive(1, 0, 1, 6'b111111, 6'b000000, 1, 0, 1, 7, 2);
    for (int i = 1; i <= 7; i++) drive(1, 0, 1, 6'b000000, 6'b000000, 1, 0, 0, 7 - i, 2);
    drive(1, 0, 1, 6'b000000, 6'b000000, 0, 0, 0, 0, 2);

    // Scaling T=4 with constant D=+1
    drive(2, 1, 1, 6'b000000, 6'b000000, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 12; k++)
      drive(2, 0, 1, 6'b000001, 6'b000000, (k % 4) == 0, 0, 0, k % 4, -1);

    @(negedge CLK);
    r_en = '0;
    @(negedge CLK);
    @(negedge CLK);
    r_checks++;
    if (r_q.size() != 0) begin
      r_errors++;
      $display("FAIL drain_queue: got %0d pending, want 0", r_q.size());
    end
    $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
    $finish;
  end

endmodule
`default_nettype wire
